// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES AHB-Lite front end.
//   - register offsets of the bus-visible register map
//   - HTRANS / HSIZE encodings used by the address-phase decoder
//   - bus-side and core-side FSM state enums
//   - register-region enum and the address decoder that produces it
package aes_pkg;

  localparam logic [7:0] KEY_BASE   = 8'h00;
  localparam logic [7:0] DATA_BASE  = 8'h10;
  localparam logic [7:0] CTRL_OFF   = 8'h20;
  localparam logic [7:0] STATUS_OFF = 8'h24;
  localparam logic [7:0] RES_BASE   = 8'h30;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    B_IDLE  = 3'd0,
    B_DATA  = 3'd1,
    B_STALL = 3'd2,
    B_ERR1  = 3'd3,
    B_ERR2  = 3'd4
  } bus_state_e;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_START = 2'd1,
    C_WAIT  = 2'd2
  } core_state_e;

  typedef enum logic [2:0] {
    R_KEY    = 3'd0,
    R_DATA   = 3'd1,
    R_CTRL   = 3'd2,
    R_STATUS = 3'd3,
    R_RES    = 3'd4,
    R_NONE   = 3'd5
  } region_e;

  // Maps a zero-extended byte address onto a register region. Anything not
  // word aligned or outside the map decodes to R_NONE.
  function automatic region_e decode_region(input logic [31:0] addr);
    region_e r;
    r = R_NONE;
    if (addr[1:0] == 2'b00) begin
      if (addr[31:4] == {24'd0, KEY_BASE[7:4]})        r = R_KEY;
      else if (addr[31:4] == {24'd0, DATA_BASE[7:4]})  r = R_DATA;
      else if (addr[31:4] == {24'd0, RES_BASE[7:4]})   r = R_RES;
      else if (addr == {24'd0, CTRL_OFF})              r = R_CTRL;
      else if (addr == {24'd0, STATUS_OFF})            r = R_STATUS;
      else                                             r = R_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_reg_bank.sv
// aes_reg_bank: 128-bit KEY, DATA and RES storage for the AES front end.
//   clk, rst     : clock, synchronous active-high reset (all storage to 0)
//   i_key_we     : per-word KEY write enables, bit i = word index i
//   i_data_we    : per-word DATA write enables, bit i = word index i
//   i_wdata      : 32-bit word written by the enables above
//   i_res_we     : load the whole 128-bit result
//   i_res        : result from the core
//   i_rd_sel     : read source, 0=KEY 1=DATA 2=RES
//   i_rd_idx     : word index of the read
//   o_rdata      : selected 32-bit word
//   o_key/o_data : full registers driven to the core
// Word index 0 is bits [127:96], index 3 is bits [31:0].
module aes_reg_bank (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   i_key_we,
  input  logic [3:0]   i_data_we,
  input  logic [31:0]  i_wdata,
  input  logic         i_res_we,
  input  logic [127:0] i_res,
  input  logic [1:0]   i_rd_sel,
  input  logic [1:0]   i_rd_idx,
  output logic [31:0]  o_rdata,
  output logic [127:0] o_key,
  output logic [127:0] o_data
);

  logic [127:0] r_key;
  logic [127:0] r_data;
  logic [127:0] r_res;
  logic [127:0] w_rd_vec;
  logic [6:0]   w_rd_lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= '0;
      r_data <= '0;
      r_res  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i_key_we[i])  r_key[(3 - i) * 32 +: 32]  <= i_wdata;
        if (i_data_we[i]) r_data[(3 - i) * 32 +: 32] <= i_wdata;
      end
      if (i_res_we) r_res <= i_res;
    end
  end

  // ~idx turns word index 0..3 into slice position 3..0 (MSB word first).
  assign w_rd_lsb = {~i_rd_idx, 5'b00000};

  always_comb begin
    w_rd_vec = r_key;
    case (i_rd_sel)
      2'd1:    w_rd_vec = r_data;
      2'd2:    w_rd_vec = r_res;
      default: w_rd_vec = r_key;
    endcase
    o_rdata = w_rd_vec[w_rd_lsb +: 32];
  end

  assign o_key  = r_key;
  assign o_data = r_data;

endmodule

// File: rtl/aes_ahb_frontend.sv
// aes_ahb_frontend: AHB-Lite slave in front of the AES encryption core.
//   clk, rst          : clock, synchronous active-high reset
//   HSEL..HREADY      : AHB-Lite slave inputs (ADDR_W-bit byte address)
//   HRDATA            : read data, valid with HREADYOUT=1 in a read data phase
//   HREADYOUT, HRESP  : slave ready / response (two-cycle ERROR)
//   aes_start         : one-cycle start pulse to the core
//   aes_key, aes_data : 128-bit key and plaintext to the core
//   aes_done          : core result strobe, honoured only while waiting
//   aes_result        : core output, captured into RES on aes_done
//   o_dbg_state       : {bus FSM state, core FSM state} for checkers
//
// Handshake: an address phase is taken on a rising edge where
// HSEL & HREADY & (HTRANS is NONSEQ or SEQ). Its data phase completes on the
// first later edge where HREADYOUT=1; nothing in this block changes state for
// that transfer before then, and HRDATA/HRESP are only meaningful while the
// data phase is open.
module aes_ahb_frontend
  import aes_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              aes_start,
  output logic [127:0]      aes_key,
  output logic [127:0]      aes_data,
  input  logic              aes_done,
  input  logic [127:0]      aes_result,
  output logic [4:0]        o_dbg_state
);

  bus_state_e  r_bus_state;
  bus_state_e  w_bus_next;
  core_state_e r_core_state;
  core_state_e w_core_next;

  // Registered address-phase information, consumed in the data phase.
  region_e     r_region;
  logic [1:0]  r_idx;
  logic        r_write;
  logic        r_done;

  region_e     w_region;
  logic        w_accept;
  logic        w_take_addr;
  logic        w_addr_err;
  logic        w_res_stall;
  logic        w_busy;
  logic        w_busy_next;
  logic        w_wr_done;
  logic        w_start_req;
  logic        w_core_start;
  logic        w_core_done;
  logic        w_status_clr;
  logic [3:0]  w_key_we;
  logic [3:0]  w_data_we;
  logic [1:0]  w_rd_sel;
  logic [31:0] w_bank_rdata;
  logic [31:0] w_rd_word;

  // ---------------- address phase decode ----------------
  assign w_accept = HSEL & HREADY &
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_region = decode_region(32'(HADDR));

  // Busy is judged against the core state the data phase will actually see,
  // so a start completing on this same edge already blocks KEY/DATA writes
  // and a done arriving on this edge already releases a RES read.
  assign w_busy      = (r_core_state != C_IDLE);
  assign w_busy_next = (w_core_next != C_IDLE);

  assign w_addr_err  = (w_region == R_NONE) || (HSIZE != HSIZE_WORD) ||
                       (HWRITE && ((w_region == R_KEY) || (w_region == R_DATA)) &&
                        w_busy_next);
  assign w_res_stall = !HWRITE && (w_region == R_RES) && w_busy_next;

  // ---------------- data phase effects ----------------
  // B_DATA always completes on the coming edge (HREADYOUT=1 there).
  assign w_wr_done    = (r_bus_state == B_DATA) && r_write;
  assign w_start_req  = w_wr_done && (r_region == R_CTRL) && HWDATA[0];
  assign w_status_clr = w_wr_done && (r_region == R_STATUS) && HWDATA[1];
  assign w_core_start = w_start_req && (r_core_state == C_IDLE);
  assign w_core_done  = (r_core_state == C_WAIT) && aes_done;

  assign w_key_we  = (w_wr_done && (r_region == R_KEY))  ? (4'b0001 << r_idx) : 4'b0000;
  assign w_data_we = (w_wr_done && (r_region == R_DATA)) ? (4'b0001 << r_idx) : 4'b0000;

  // ---------------- core FSM ----------------
  always_comb begin
    w_core_next = r_core_state;
    aes_start   = 1'b0;
    case (r_core_state)
      C_IDLE:  if (w_start_req) w_core_next = C_START;
      C_START: begin
        aes_start   = 1'b1;
        w_core_next = C_WAIT;
      end
      C_WAIT:  if (aes_done) w_core_next = C_IDLE;
      default: w_core_next = C_IDLE;
    endcase
  end

  // ---------------- bus FSM ----------------
  always_comb begin
    w_bus_next  = r_bus_state;
    w_take_addr = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (r_bus_state)
      B_IDLE, B_DATA, B_ERR2: begin
        // Second ERROR cycle is ready, so it overlaps the next address phase.
        if (r_bus_state == B_ERR2) HRESP = 1'b1;
        w_take_addr = w_accept;
        if (!w_accept)        w_bus_next = B_IDLE;
        else if (w_addr_err)  w_bus_next = B_ERR1;
        else if (w_res_stall) w_bus_next = B_STALL;
        else                  w_bus_next = B_DATA;
      end
      B_STALL: begin
        HREADYOUT = 1'b0;
        // Leave once the result is being latched; the read completes next cycle.
        if (!w_busy_next) w_bus_next = B_DATA;
      end
      B_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        w_bus_next = B_ERR2;
      end
      default: w_bus_next = B_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_state  <= B_IDLE;
      r_core_state <= C_IDLE;
      r_region     <= R_NONE;
      r_idx        <= 2'd0;
      r_write      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_bus_state  <= w_bus_next;
      r_core_state <= w_core_next;
      if (w_take_addr) begin
        r_region <= w_region;
        r_idx    <= HADDR[3:2];
        r_write  <= HWRITE;
      end
      if (w_core_done)                        r_done <= 1'b1;
      else if (w_core_start || w_status_clr)  r_done <= 1'b0;
    end
  end

  // ---------------- storage ----------------
  always_comb begin
    w_rd_sel = 2'd0;
    case (r_region)
      R_DATA:  w_rd_sel = 2'd1;
      R_RES:   w_rd_sel = 2'd2;
      default: w_rd_sel = 2'd0;
    endcase
  end

  aes_reg_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_key_we  (w_key_we),
    .i_data_we (w_data_we),
    .i_wdata   (HWDATA),
    .i_res_we  (w_core_done),
    .i_res     (aes_result),
    .i_rd_sel  (w_rd_sel),
    .i_rd_idx  (r_idx),
    .o_rdata   (w_bank_rdata),
    .o_key     (aes_key),
    .o_data    (aes_data)
  );

  // ---------------- read data ----------------
  // STATUS reflects the registered flags, so a read coinciding with aes_done
  // returns the value from before the update.
  always_comb begin
    w_rd_word = 32'd0;
    case (r_region)
      R_KEY, R_DATA, R_RES: w_rd_word = w_bank_rdata;
      R_STATUS:             w_rd_word = {30'd0, r_done, w_busy};
      default:              w_rd_word = 32'd0;
    endcase
    HRDATA = 32'd0;
    if ((r_bus_state == B_DATA) && !r_write) HRDATA = w_rd_word;
  end

  assign o_dbg_state = {r_bus_state, r_core_state};

endmodule

// File: tb/tb_aes_ahb_frontend.sv
// Testbench for aes_ahb_frontend: directed register-map, start, stall, error
// and reset cases, then randomized traffic checked against a word-level model.
module tb_aes_ahb_frontend;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         HSEL;
  logic [7:0]   HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic [31:0]  HRDATA;
  logic         HREADYOUT;
  logic         HRESP;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_data;
  logic         aes_done;
  logic [127:0] aes_result;
  logic [4:0]   dbg_state;

  assign HREADY = HREADYOUT;

  aes_ahb_frontend #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .aes_start   (aes_start),
    .aes_key     (aes_key),
    .aes_data    (aes_data),
    .aes_done    (aes_done),
    .aes_result  (aes_result),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_bad    = 0;
  logic [31:0] exp_q[$];

  logic [31:0] key_m[4];
  logic [31:0] data_m[4];
  logic [31:0] res_m[4];
  logic        done_m;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    return (a[1:0] == 2'b00) && ((a < 8'h28) || ((a >= 8'h30) && (a < 8'h40)));
  endfunction

  // Read value of a mapped address while the core is idle.
  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [1:0] w;
    w = a[3:2];
    if (a < 8'h10)       return key_m[w];
    else if (a < 8'h20)  return data_m[w];
    else if (a >= 8'h30) return res_m[w];
    else if (a == 8'h24) return {30'd0, done_m, 1'b0};
    else                 return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      key_m[i] = '0; data_m[i] = '0; res_m[i] = '0;
    end
    done_m = 1'b0;
  endtask

  task automatic model_set_res(input logic [127:0] r);
    res_m[0] = r[127:96]; res_m[1] = r[95:64]; res_m[2] = r[63:32]; res_m[3] = r[31:0];
  endtask

  // ---------------- behavioural AES core ----------------
  int           core_lat = 12;
  logic [127:0] core_res = '0;
  int           core_cnt = 0;
  int           start_cnt = 0;

  always @(negedge clk) if (aes_start === 1'b1) start_cnt++;

  initial begin : core_model
    aes_done   = 1'b0;
    aes_result = '0;
    forever begin
      @(posedge clk); #1;
      aes_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          aes_done   = 1'b1;
          aes_result = core_res;
        end
      end else if (aes_start === 1'b1) begin
        core_cnt = core_lat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1: one non-pipelined transfer.
  task automatic ahb_xfer(input logic wr, input logic [7:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic resp_first, output logic resp_last, output int waits);
    int guard;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0; guard = 0;
    @(negedge clk);
    resp_first = HRESP;
    while (HREADYOUT !== 1'b1 && guard < 200) begin
      waits++; guard++;
      @(negedge clk);
    end
    if (guard >= 200) check_val("xfer_timeout", 1'b0, 1'b1);
    rdata     = HRDATA;
    resp_last = HRESP;
    @(posedge clk); #1;
  endtask

  task automatic wr_okay(input string tag, input logic [7:0] addr, input logic [31:0] d);
    logic [31:0] rd; logic rf, rl; int w;
    ahb_xfer(1'b1, addr, 3'b010, d, rd, rf, rl, w);
    check_val({tag, "_resp"}, rl, 1'b0);
    check_val({tag, "_waits"}, w, 0);
  endtask

  task automatic rd_okay(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic rf, rl; int w;
    ahb_xfer(1'b0, addr, 3'b010, 32'd0, rd, rf, rl, w);
    check_val({tag, "_resp"}, rl, 1'b0);
    check_val({tag, "_waits"}, w, 0);
    check_val({tag, "_data"}, rd, exp);
  endtask

  task automatic xfer_err(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [2:0] size, input logic [31:0] d);
    logic [31:0] rd; logic rf, rl; int w;
    ahb_xfer(wr, addr, size, d, rd, rf, rl, w);
    check_val({tag, "_err_c1"}, rf, 1'b1);
    check_val({tag, "_err_c2"}, rl, 1'b1);
    check_val({tag, "_err_waits"}, w, 1);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] rd; logic rf, rl; int w; int n;
    rd = '0; n = 0;
    while (rd != 32'h2 && n < 100) begin
      ahb_xfer(1'b0, 8'h24, 3'b010, 32'd0, rd, rf, rl, w);
      n++;
    end
    check_val(tag, rd, 32'h2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] rd, v;
    logic rf, rl;
    int w, s0, sel, idx;
    logic [7:0] a;
    logic [2:0] sz;

    HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 3'b010; HWDATA = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_hreadyout", HREADYOUT, 1'b1);
    check_val("rst_hresp", HRESP, 1'b0);
    check_val("rst_hrdata", HRDATA, 32'd0);
    check_val("rst_start", aes_start, 1'b0);
    check_val("rst_key", aes_key, 128'd0);
    check_val("rst_data", aes_data, 128'd0);
    check_val("rst_dbg", dbg_state, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_okay("rst_status", 8'h24, 32'h0);
    rd_okay("rst_res0", 8'h30, 32'h0);

    // KEY load
    key_m[0] = 32'h2B7E1516; key_m[1] = 32'h28AED2A6;
    key_m[2] = 32'hABF71588; key_m[3] = 32'h09CF4F3C;
    for (int i = 0; i < 4; i++) wr_okay("key_wr", 8'(4 * i), key_m[i]);
    check_val("key_vec", aes_key, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
    for (int i = 0; i < 4; i++) begin
      data_m[i] = $urandom;
      wr_okay("data_wr", 8'(8'h10 + 4 * i), data_m[i]);
    end
    check_val("data_vec", aes_data, pack4(data_m[0], data_m[1], data_m[2], data_m[3]));
    rd_okay("key2_rd", 8'h08, 32'hABF71588);

    // First encryption
    core_lat = 12;
    core_res = 128'h3925841D02DC09FBDC118597196A0B32;
    s0 = start_cnt;
    wr_okay("ctrl_start", 8'h20, 32'h1);
    @(negedge clk);
    check_val("start_pulse", aes_start, 1'b1);
    @(negedge clk);
    check_val("start_one_cycle", aes_start, 1'b0);
    @(posedge clk); #1;
    rd_okay("status_wait", 8'h24, 32'h1);
    rd_okay("ctrl_rd", 8'h20, 32'h0);
    wait_done("status_done");
    check_val("start_count1", start_cnt - s0, 1);
    model_set_res(core_res); done_m = 1'b1;
    rd_okay("res0_rd", 8'h30, 32'h3925841D);
    wr_okay("res_wr_ignored", 8'h30, 32'hFFFFFFFF);
    rd_okay("res0_after_wr", 8'h30, 32'h3925841D);

    // RES read stalls while busy
    wr_okay("ctrl_start2", 8'h20, 32'h1);
    ahb_xfer(1'b0, 8'h34, 3'b010, 32'd0, rd, rf, rl, w);
    check_val("stall_waits", w, 12);
    check_val("stall_data", rd, 32'h02DC09FB);
    check_val("stall_resp", rl, 1'b0);
    rd_okay("status_after_stall", 8'h24, 32'h2);

    // Error responses
    xfer_err("byte_wr", 1'b1, 8'h00, 3'b000, 32'hDEADBEEF);
    xfer_err("unmapped_rd", 1'b0, 8'h50, 3'b010, 32'd0);
    check_val("key_after_err", aes_key, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
    rd_okay("key0_after_err", 8'h00, 32'h2B7E1516);

    // Writes while busy
    core_lat = 20;
    core_res = {$urandom, $urandom, $urandom, $urandom};
    s0 = start_cnt;
    wr_okay("ctrl_start3", 8'h20, 32'h1);
    xfer_err("busy_data_wr", 1'b1, 8'h18, 3'b010, 32'h12345678);
    check_val("data_after_busy", aes_data, pack4(data_m[0], data_m[1], data_m[2], data_m[3]));
    wr_okay("ctrl_while_busy", 8'h20, 32'h1);
    wait_done("busy_done");
    check_val("start_count3", start_cnt - s0, 1);
    model_set_res(core_res); done_m = 1'b1;
    rd_okay("res3_rd", 8'h3C, res_m[3]);

    // Reset during a RES stall
    core_lat = 12;
    core_res = {$urandom, $urandom, $urandom, $urandom};
    wr_okay("ctrl_start4", 8'h20, 32'h1);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h34; HWRITE = 1'b0; HSIZE = 3'b010;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(negedge clk);
    check_val("stall_hold", HREADYOUT, 1'b0);
    s0 = start_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_stall_ready", HREADYOUT, 1'b1);
    check_val("rst_stall_key", aes_key, 128'd0);
    check_val("rst_stall_start", aes_start, 1'b0);
    check_val("rst_stall_dbg", dbg_state, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rd_okay("rst_stall_status", 8'h24, 32'h0);
    w = 0;
    while (core_cnt != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    rd_okay("late_done_status", 8'h24, 32'h0);
    rd_okay("late_done_res", 8'h30, 32'h0);
    check_val("late_done_nostart", start_cnt - s0, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          sel = $urandom_range(0, 1); idx = $urandom_range(0, 3); v = $urandom;
          a = (sel != 0 ? 8'h10 : 8'h00) + 8'(idx * 4);
          if (sel != 0) data_m[idx] = v; else key_m[idx] = v;
          wr_okay("rnd_wr", a, v);
          check_val("rnd_key", aes_key, pack4(key_m[0], key_m[1], key_m[2], key_m[3]));
          check_val("rnd_data", aes_data, pack4(data_m[0], data_m[1], data_m[2], data_m[3]));
        end
        1: begin
          a = 8'($urandom_range(0, 7) * 4);
          rd_okay("rnd_rd", a, model_read(a));
        end
        2: rd_okay("rnd_status", 8'h24, model_read(8'h24));
        3: begin
          a  = 8'($urandom_range(0, 255));
          sz = ($urandom_range(0, 3) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
          if (!is_mapped(a) || sz != 3'b010) begin
            xfer_err("rnd_err", 1'b0, a, sz, 32'd0);
            check_val("rnd_err_key", aes_key, pack4(key_m[0], key_m[1], key_m[2], key_m[3]));
          end else begin
            rd_okay("rnd_any_rd", a, model_read(a));
          end
        end
        4: begin
          core_lat = $urandom_range(2, 10);
          core_res = {$urandom, $urandom, $urandom, $urandom};
          s0 = start_cnt;
          wr_okay("rnd_start", 8'h20, $urandom | 32'h1);
          wait_done("rnd_done");
          check_val("rnd_start_cnt", start_cnt - s0, 1);
          model_set_res(core_res); done_m = 1'b1;
          for (int i = 0; i < 4; i++) exp_q.push_back(res_m[i]);
          for (int i = 0; i < 4; i++) rd_okay("rnd_res", 8'(8'h30 + 4 * i), exp_q.pop_front());
        end
        default: begin
          v = $urandom;
          if (v[1]) done_m = 1'b0;
          wr_okay("rnd_status_wr", 8'h24, v);
          rd_okay("rnd_status_clr", 8'h24, model_read(8'h24));
        end
      endcase
    end

    check_val("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
